// File: rtl/gray_counter_conv_if.sv
// Valid/ready converter channel of the Gray-code unit.
// The master side produces words and consumes results. The slave side is the converter.
interface gray_counter_conv_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cv_dir;
  logic             cv_valid;
  logic             cv_ready;
  logic [WIDTH-1:0] cv_in;
  logic [WIDTH-1:0] cv_out;
  logic             cv_ovalid;
  logic             cv_oready;

  modport master (
    output cv_dir, cv_valid, cv_in, cv_oready,
    input  cv_ready, cv_out, cv_ovalid
  );

  modport slave (
    input  cv_dir, cv_valid, cv_in, cv_oready,
    output cv_ready, cv_out, cv_ovalid
  );
endinterface

// File: rtl/gray_counter_conv.sv
// Gray-code unit with two independent sections.
// The first is an up/down/load counter that outputs binary and registered Gray.
// The second is a 1-deep binary<->Gray converter with a valid/ready handshake.
module gray_counter_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_en,
  input  logic                 cnt_up,
  input  logic                 cnt_load,
  input  logic [WIDTH-1:0]     cnt_din,
  output logic [WIDTH-1:0]     cnt_bin,
  output logic [WIDTH-1:0]     cnt_gray,
  output logic                 cnt_wrap,
  gray_counter_conv_if.slave   cv
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Counter next value; Gray is encoded from the next value so it is registered in step.
  logic [WIDTH-1:0] cnt_next;
  logic             wrap_next;

  always_comb begin
    cnt_next  = cnt_bin;
    wrap_next = 1'b0;
    if (cnt_load) begin
      cnt_next = cnt_din;
    end else if (cnt_en) begin
      if (cnt_up) begin
        cnt_next  = cnt_bin + WIDTH'(1);
        wrap_next = (cnt_bin == CNT_MAX);
      end else begin
        cnt_next  = cnt_bin - WIDTH'(1);
        wrap_next = (cnt_bin == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_bin  <= '0;
      cnt_gray <= '0;
      cnt_wrap <= 1'b0;
    end else begin
      cnt_bin  <= cnt_next;
      cnt_gray <= bin2gray(cnt_next);
      cnt_wrap <= wrap_next;
    end
  end

  // The converter accepts whenever its single output slot is free or draining this cycle.
  logic             cv_accept;
  logic [WIDTH-1:0] cv_conv;

  assign cv.cv_ready = !cv.cv_ovalid || cv.cv_oready;
  assign cv_accept   = cv.cv_valid && cv.cv_ready;
  assign cv_conv     = cv.cv_dir ? gray2bin(cv.cv_in) : bin2gray(cv.cv_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cv.cv_out    <= '0;
      cv.cv_ovalid <= 1'b0;
    end else if (cv_accept) begin
      cv.cv_out    <= cv_conv;
      cv.cv_ovalid <= 1'b1;
    end else if (cv.cv_oready) begin
      cv.cv_ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter_conv.sv
// Directed self-checking bench for gray_counter_conv at WIDTH=4 and WIDTH=8.
module tb_gray_counter_conv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       cnt_en4, cnt_up4, cnt_load4, cnt_wrap4;
  logic [3:0] cnt_din4, cnt_bin4, cnt_gray4;
  logic       cnt_en8, cnt_up8, cnt_load8, cnt_wrap8;
  logic [7:0] cnt_din8, cnt_bin8, cnt_gray8;

  gray_counter_conv_if #(.WIDTH(4)) cv4 ();
  gray_counter_conv_if #(.WIDTH(8)) cv8 ();

  gray_counter_conv #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .cnt_en(cnt_en4), .cnt_up(cnt_up4), .cnt_load(cnt_load4), .cnt_din(cnt_din4),
    .cnt_bin(cnt_bin4), .cnt_gray(cnt_gray4), .cnt_wrap(cnt_wrap4),
    .cv(cv4)
  );

  gray_counter_conv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .cnt_en(cnt_en8), .cnt_up(cnt_up8), .cnt_load(cnt_load8), .cnt_din(cnt_din8),
    .cnt_bin(cnt_bin8), .cnt_gray(cnt_gray8), .cnt_wrap(cnt_wrap8),
    .cv(cv8)
  );

  int n_checks = 0;
  int n_fails  = 0;

  int gray4 [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_b2g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] prev4;
  logic [7:0] prev8;

  initial begin
    rst_n = 1'b0;
    cnt_en4 = 1'b0; cnt_up4 = 1'b1; cnt_load4 = 1'b0; cnt_din4 = '0;
    cnt_en8 = 1'b0; cnt_up8 = 1'b1; cnt_load8 = 1'b0; cnt_din8 = '0;
    cv4.cv_dir = 1'b0; cv4.cv_valid = 1'b0; cv4.cv_in = '0; cv4.cv_oready = 1'b1;
    cv8.cv_dir = 1'b0; cv8.cv_valid = 1'b0; cv8.cv_in = '0; cv8.cv_oready = 1'b1;

    // Reset state
    tick;
    tick;
    check("rst_bin",    32'(cnt_bin4), 32'd0);
    check("rst_gray",   32'(cnt_gray4), 32'd0);
    check("rst_wrap",   32'(cnt_wrap4), 32'd0);
    check("rst_cvout",  32'(cv4.cv_out), 32'd0);
    check("rst_ovalid", 32'(cv4.cv_ovalid), 32'd0);
    check("rst_ready",  32'(cv4.cv_ready), 32'd1);
    rst_n = 1'b1;

    // Count up through a full wrap
    cnt_en4 = 1'b1; cnt_up4 = 1'b1;
    prev4 = cnt_gray4;
    for (int i = 1; i <= 16; i++) begin
      tick;
      check("up_bin",  32'(cnt_bin4), 32'(i % 16));
      check("up_gray", 32'(cnt_gray4), 32'(gray4[i % 16]));
      check("up_wrap", 32'(cnt_wrap4), (i == 16) ? 32'd1 : 32'd0);
      check("up_hamming", 32'($countones(prev4 ^ cnt_gray4)), 32'd1);
      prev4 = cnt_gray4;
    end

    // Step down from 0, then hold
    cnt_up4 = 1'b0;
    tick;
    check("dn_bin",  32'(cnt_bin4), 32'hF);
    check("dn_gray", 32'(cnt_gray4), 32'h8);
    check("dn_wrap", 32'(cnt_wrap4), 32'd1);
    cnt_en4 = 1'b0;
    tick;
    check("hold_wrap", 32'(cnt_wrap4), 32'd0);
    check("hold_bin",  32'(cnt_bin4), 32'hF);

    // Load wins over enable
    cnt_load4 = 1'b1; cnt_din4 = 4'b1001; cnt_en4 = 1'b1; cnt_up4 = 1'b1;
    tick;
    check("ld_bin",  32'(cnt_bin4), 32'h9);
    check("ld_gray", 32'(cnt_gray4), 32'hD);
    check("ld_wrap", 32'(cnt_wrap4), 32'd0);
    cnt_load4 = 1'b0; cnt_en4 = 1'b0;

    // Converter directed words
    cv4.cv_oready = 1'b1; cv4.cv_valid = 1'b1;
    cv4.cv_dir = 1'b0; cv4.cv_in = 4'b1011;
    tick;
    check("cv_b2g",    32'(cv4.cv_out), 32'hE);
    check("cv_ovalid", 32'(cv4.cv_ovalid), 32'd1);
    cv4.cv_dir = 1'b1; cv4.cv_in = 4'b1110;
    tick;
    check("cv_g2b", 32'(cv4.cv_out), 32'hB);

    // Back-to-back sweeps in both directions
    for (int x = 0; x < 16; x++) begin
      cv4.cv_dir = 1'b0; cv4.cv_in = 4'(x);
      tick;
      check("sw_b2g",    32'(cv4.cv_out), 32'(gray4[x]));
      check("sw_ovalid", 32'(cv4.cv_ovalid), 32'd1);
    end
    for (int x = 0; x < 16; x++) begin
      cv4.cv_dir = 1'b1; cv4.cv_in = 4'(gray4[x]);
      tick;
      check("sw_g2b",    32'(cv4.cv_out), 32'(x));
      check("sw_ovalid", 32'(cv4.cv_ovalid), 32'd1);
    end
    cv4.cv_valid = 1'b0;
    tick;
    check("drain_ovalid", 32'(cv4.cv_ovalid), 32'd0);
    check("drain_hold",   32'(cv4.cv_out), 32'hF);

    // Backpressure, then drain and reload in one cycle
    cv4.cv_valid = 1'b1; cv4.cv_dir = 1'b0; cv4.cv_in = 4'd5; cv4.cv_oready = 1'b0;
    tick;
    check("bp_out",   32'(cv4.cv_out), 32'h7);
    check("bp_ready", 32'(cv4.cv_ready), 32'd0);
    cv4.cv_in = 4'd6;
    tick;
    check("bp_stable", 32'(cv4.cv_out), 32'h7);
    check("bp_ovalid", 32'(cv4.cv_ovalid), 32'd1);
    cv4.cv_oready = 1'b1;
    #1;
    check("bp_ready_up", 32'(cv4.cv_ready), 32'd1);
    tick;
    check("bp_reload", 32'(cv4.cv_out), 32'h5);
    check("bp_reload_v", 32'(cv4.cv_ovalid), 32'd1);
    cv4.cv_valid = 1'b0;
    tick;
    check("bp_empty", 32'(cv4.cv_ovalid), 32'd0);

    // Reset while counting and while a word is pending
    cnt_en4 = 1'b1; cnt_up4 = 1'b1;
    cv4.cv_valid = 1'b1; cv4.cv_in = 4'd3; cv4.cv_oready = 1'b0;
    tick;
    check("pre_rst_out", 32'(cv4.cv_out), 32'h2);
    check("pre_rst_bin", 32'(cnt_bin4), 32'hA);
    rst_n = 1'b0;
    tick;
    check("mid_rst_bin",    32'(cnt_bin4), 32'd0);
    check("mid_rst_gray",   32'(cnt_gray4), 32'd0);
    check("mid_rst_wrap",   32'(cnt_wrap4), 32'd0);
    check("mid_rst_out",    32'(cv4.cv_out), 32'd0);
    check("mid_rst_ovalid", 32'(cv4.cv_ovalid), 32'd0);
    rst_n = 1'b1; cnt_en4 = 1'b0; cv4.cv_valid = 1'b0; cv4.cv_oready = 1'b1;
    tick;
    check("post_rst_bin",    32'(cnt_bin4), 32'd0);
    check("post_rst_wrap",   32'(cnt_wrap4), 32'd0);
    check("post_rst_ovalid", 32'(cv4.cv_ovalid), 32'd0);

    // WIDTH=8 counter: full wrap at 255
    cnt_en8 = 1'b1; cnt_up8 = 1'b1;
    prev8 = cnt_gray8;
    for (int i = 1; i <= 256; i++) begin
      tick;
      check("w8_bin",  32'(cnt_bin8), 32'(i % 256));
      check("w8_gray", 32'(cnt_gray8), 32'(ref_b2g8(8'(i % 256))));
      check("w8_wrap", 32'(cnt_wrap8), (i == 256) ? 32'd1 : 32'd0);
      check("w8_hamming", 32'($countones(prev8 ^ cnt_gray8)), 32'd1);
      if (i == 255) check("w8_gray_max", 32'(cnt_gray8), 32'h80);
      prev8 = cnt_gray8;
    end
    cnt_up8 = 1'b0;
    tick;
    check("w8_dn_bin",  32'(cnt_bin8), 32'hFF);
    check("w8_dn_gray", 32'(cnt_gray8), 32'h80);
    check("w8_dn_wrap", 32'(cnt_wrap8), 32'd1);
    cnt_en8 = 1'b0;

    // WIDTH=8 converter: directed words back-to-back
    cv8.cv_valid = 1'b1; cv8.cv_oready = 1'b1;
    cv8.cv_dir = 1'b0; cv8.cv_in = 8'hB5;
    tick;
    check("w8_b2g_b5", 32'(cv8.cv_out), 32'hEF);
    cv8.cv_dir = 1'b1; cv8.cv_in = 8'hEF;
    tick;
    check("w8_g2b_ef", 32'(cv8.cv_out), 32'hB5);
    cv8.cv_dir = 1'b0; cv8.cv_in = 8'h80;
    tick;
    check("w8_b2g_80", 32'(cv8.cv_out), 32'hC0);
    cv8.cv_dir = 1'b1; cv8.cv_in = 8'h80;
    tick;
    check("w8_g2b_80", 32'(cv8.cv_out), 32'hFF);
    check("w8_ovalid", 32'(cv8.cv_ovalid), 32'd1);
    cv8.cv_valid = 1'b0;
    tick;
    check("w8_drain", 32'(cv8.cv_ovalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
